regfile_sb: RTL and testbench

//  Parametrised integer register file with per-register busy scoreboard for the RV32I core.

---
 rtl/regfile_sb_pkg.sv | 11 +
 rtl/regfile_rdport.sv | 68 ++++++
 rtl/regfile_sb.sv | 107 ++++++++++
 tb/tb_regfile_sb.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_sb_pkg.sv
// Shared constants for the regfile_sb register file and its read ports.
//   XLEN_DEF  : default data width
//   NREGS_DEF : default number of architectural registers
//   REG_ZERO  : index of the hardwired-zero register
package regfile_sb_pkg;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned NREGS_DEF = 32;
    localparam int unsigned REG_ZERO  = 0;

endpackage

// File: rtl/regfile_rdport.sv
// One read port of regfile_sb: register mux, zero-register check and optional
// same-cycle write bypass (enabled by defining REGFILE_BYPASS_EN).
// Ports:
//   i_addr       read address
//   i_regs       flattened register contents, reg i at [i*XLEN +: XLEN]
//   i_busy       busy vector, one bit per register
//   i_wr_en      per-write-port enable (already gated by reset)
//   i_wr_addr    write addresses, port p at [p*AW +: AW]
//   i_wr_data    write data, port p at [p*XLEN +: XLEN]
//   i_alloc_en   allocation enable (already gated by reset)
//   i_alloc_addr allocation address
//   o_data       read data
//   o_busy       busy flag of the addressed register
module regfile_rdport
    import regfile_sb_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_DEF,
    parameter int unsigned NREGS  = NREGS_DEF,
    parameter int unsigned NUM_WR = 1,
    localparam int unsigned AW    = $clog2(NREGS)
) (
    input  logic [AW-1:0]          i_addr,
    input  logic [NREGS*XLEN-1:0]  i_regs,
    input  logic [NREGS-1:0]       i_busy,
    input  logic [NUM_WR-1:0]      i_wr_en,
    input  logic [NUM_WR*AW-1:0]   i_wr_addr,
    input  logic [NUM_WR*XLEN-1:0] i_wr_data,
    input  logic                   i_alloc_en,
    input  logic [AW-1:0]          i_alloc_addr,
    output logic [XLEN-1:0]        o_data,
    output logic                   o_busy
);

    logic w_is_zero;
    assign w_is_zero = (i_addr == AW'(REG_ZERO));

`ifdef REGFILE_BYPASS_EN
    always_comb begin
        o_data = i_regs[int'(i_addr)*XLEN +: XLEN];
        o_busy = i_busy[i_addr];
        // Ascending scan so the highest-index matching write port wins.
        for (int p = 0; p < int'(NUM_WR); p++) begin
            if (i_wr_en[p] && (i_wr_addr[p*AW +: AW] == i_addr)) begin
                o_data = i_wr_data[p*XLEN +: XLEN];
                o_busy = i_alloc_en && (i_alloc_addr == i_addr);
            end
        end
        if (w_is_zero) begin
            o_data = '0;
            o_busy = 1'b0;
        end
    end
`else
    always_comb begin
        o_data = i_regs[int'(i_addr)*XLEN +: XLEN];
        o_busy = i_busy[i_addr];
        if (w_is_zero) begin
            o_data = '0;
            o_busy = 1'b0;
        end
    end

    // Bypass inputs are only consumed when the bypass is built in.
    logic w_unused_bypass;
    assign w_unused_bypass = ^{i_wr_en, i_wr_addr, i_wr_data, i_alloc_en, i_alloc_addr};
`endif

endmodule

// File: rtl/regfile_sb.sv
// Parametrised integer register file with a per-register busy scoreboard.
// Reg 0 reads as zero and ignores writes and allocations. Optional feature:
// define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (clears data and busy bits)
//   rd_addr    read addresses, port i at [i*AW +: AW]
//   rd_data    read data, port i at [i*XLEN +: XLEN]
//   rd_busy    per read port: addressed register has an outstanding producer
//   wr_en      per write port enable
//   wr_addr    write addresses, port p at [p*AW +: AW]
//   wr_data    write data, port p at [p*XLEN +: XLEN]
//   alloc_en   mark alloc_addr busy
//   alloc_addr destination register being allocated
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_DEF,
    parameter int unsigned NREGS  = NREGS_DEF,
    parameter int unsigned NUM_RD = 2,
    parameter int unsigned NUM_WR = 1,
    localparam int unsigned AW    = $clog2(NREGS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_RD*AW-1:0]   rd_addr,
    output logic [NUM_RD*XLEN-1:0] rd_data,
    output logic [NUM_RD-1:0]      rd_busy,
    input  logic [NUM_WR-1:0]      wr_en,
    input  logic [NUM_WR*AW-1:0]   wr_addr,
    input  logic [NUM_WR*XLEN-1:0] wr_data,
    input  logic                   alloc_en,
    input  logic [AW-1:0]          alloc_addr
);

    logic [XLEN-1:0]       r_regs [NREGS];
    logic [NREGS-1:0]      r_busy;
    logic [XLEN-1:0]       w_regs_d [NREGS];
    logic [NREGS-1:0]      w_busy_d;
    logic [NREGS*XLEN-1:0] w_regs_flat;
    logic [NUM_WR-1:0]     w_wr_en_gated;
    logic                  w_alloc_gated;

    // Keeps the bypass path quiet while reset is asserted.
    assign w_wr_en_gated = wr_en & {NUM_WR{rst_n}};
    assign w_alloc_gated = alloc_en & rst_n;

    // Ascending port order: highest-index port wins a same-address conflict.
    always_comb begin
        w_regs_d = r_regs;
        for (int p = 0; p < int'(NUM_WR); p++) begin
            if (wr_en[p] && (wr_addr[p*AW +: AW] != AW'(REG_ZERO))) begin
                w_regs_d[wr_addr[p*AW +: AW]] = wr_data[p*XLEN +: XLEN];
            end
        end
    end

    // Writes clear busy first, so an alloc to the same register leaves it set.
    always_comb begin
        w_busy_d = r_busy;
        for (int p = 0; p < int'(NUM_WR); p++) begin
            if (wr_en[p]) begin
                w_busy_d[wr_addr[p*AW +: AW]] = 1'b0;
            end
        end
        if (alloc_en) begin
            w_busy_d[alloc_addr] = 1'b1;
        end
        w_busy_d[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                r_regs[i] <= '0;
            end
            r_busy <= '0;
        end else begin
            r_regs <= w_regs_d;
            r_busy <= w_busy_d;
        end
    end

    for (genvar i = 0; i < int'(NREGS); i++) begin : g_flat
        assign w_regs_flat[i*XLEN +: XLEN] = r_regs[i];
    end

    for (genvar g = 0; g < int'(NUM_RD); g++) begin : g_rd
        regfile_rdport #(
            .XLEN   (XLEN),
            .NREGS  (NREGS),
            .NUM_WR (NUM_WR)
        ) u_rdport (
            .i_addr       (rd_addr[g*AW +: AW]),
            .i_regs       (w_regs_flat),
            .i_busy       (r_busy),
            .i_wr_en      (w_wr_en_gated),
            .i_wr_addr    (wr_addr),
            .i_wr_data    (wr_data),
            .i_alloc_en   (w_alloc_gated),
            .i_alloc_addr (alloc_addr),
            .o_data       (rd_data[g*XLEN +: XLEN]),
            .o_busy       (rd_busy[g])
        );
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb (2 read ports, 2 write ports).
// Expected read results are queued when a read is driven and popped when sampled.
module tb_regfile_sb;

    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int NUM_RD = 2;
    localparam int NUM_WR = 2;
    localparam int AW     = 5;

    logic                   clk;
    logic                   rst_n;
    logic [NUM_RD*AW-1:0]   rd_addr;
    logic [NUM_RD*XLEN-1:0] rd_data;
    logic [NUM_RD-1:0]      rd_busy;
    logic [NUM_WR-1:0]      wr_en;
    logic [NUM_WR*AW-1:0]   wr_addr;
    logic [NUM_WR*XLEN-1:0] wr_data;
    logic                   alloc_en;
    logic [AW-1:0]          alloc_addr;

    typedef struct {
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
        logic            busy;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks;
    int   n_fail;

    regfile_sb #(
        .XLEN   (XLEN),
        .NREGS  (NREGS),
        .NUM_RD (NUM_RD),
        .NUM_WR (NUM_WR)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive both read ports with one address, then compare both against the queued entry.
    task automatic read_check(input logic [AW-1:0] a, input logic [XLEN-1:0] d, input logic b);
        exp_t e;
        e.addr = a;
        e.data = d;
        e.busy = b;
        sb_q.push_back(e);
        rd_addr = {a, a};
        #1;
        e = sb_q.pop_front();
        for (int p = 0; p < NUM_RD; p++) begin
            n_checks++;
            assert (rd_data[p*XLEN +: XLEN] === e.data) else begin
                n_fail++;
                $error("FAIL rd%0d_data r%0d got=%h exp=%h", p, e.addr,
                       rd_data[p*XLEN +: XLEN], e.data);
            end
            n_checks++;
            assert (rd_busy[p] === e.busy) else begin
                n_fail++;
                $error("FAIL rd%0d_busy r%0d got=%b exp=%b", p, e.addr, rd_busy[p], e.busy);
            end
        end
    endtask

    task automatic set_wr(input int p, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        wr_en[p]               = 1'b1;
        wr_addr[p*AW +: AW]    = a;
        wr_data[p*XLEN +: XLEN] = d;
    endtask

    task automatic clear_in();
        wr_en    = '0;
        wr_addr  = '0;
        wr_data  = '0;
        alloc_en = 1'b0;
        alloc_addr = '0;
    endtask

    // Advance past one rising edge, then release the write/alloc strobes.
    task automatic tick();
        @(posedge clk);
        #1;
        clear_in();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        rd_addr  = '0;
        clear_in();

        // Reset: values read zero while held and after release.
        repeat (2) @(posedge clk);
        #1;
        read_check(5'd9, 32'h0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < NREGS; i++) begin
            read_check(AW'(i), 32'h0, 1'b0);
        end

        // Basic writes on both ports; write to r0 dropped.
        @(negedge clk);
        set_wr(0, 5'd1, 32'hAA);
        set_wr(1, 5'd2, 32'hBB);
        tick();
        read_check(5'd1, 32'hAA, 1'b0);
        read_check(5'd2, 32'hBB, 1'b0);
        set_wr(0, 5'd0, 32'hFF);
        tick();
        read_check(5'd0, 32'h0, 1'b0);
        read_check(5'd1, 32'hAA, 1'b0);

        // Same-address conflict: port 1 wins.
        set_wr(0, 5'd5, 32'h11);
        set_wr(1, 5'd5, 32'h22);
        tick();
        read_check(5'd5, 32'h22, 1'b0);

        // Scoreboard on r3.
        alloc_en   = 1'b1;
        alloc_addr = 5'd3;
        tick();
        read_check(5'd3, 32'h0, 1'b1);
        set_wr(0, 5'd3, 32'h33);
        tick();
        read_check(5'd3, 32'h33, 1'b0);
        alloc_en   = 1'b1;
        alloc_addr = 5'd3;
        set_wr(1, 5'd3, 32'h44);
        tick();
        read_check(5'd3, 32'h44, 1'b1);
        // Alloc to r0 is ignored.
        alloc_en   = 1'b1;
        alloc_addr = 5'd0;
        tick();
        read_check(5'd0, 32'h0, 1'b0);

        // Same-cycle write and read of r7.
        set_wr(0, 5'd7, 32'h77);
`ifdef REGFILE_BYPASS_EN
        read_check(5'd7, 32'h77, 1'b0);
`else
        read_check(5'd7, 32'h0, 1'b0);
`endif
        tick();
        read_check(5'd7, 32'h77, 1'b0);

        // Mid-cycle reset with a pending write to busy r4.
        alloc_en   = 1'b1;
        alloc_addr = 5'd4;
        tick();
        read_check(5'd4, 32'h0, 1'b1);
        set_wr(0, 5'd4, 32'h99);
        #2;
        rst_n = 1'b0;
        read_check(5'd4, 32'h0, 1'b0);
        read_check(5'd3, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        clear_in();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        read_check(5'd4, 32'h0, 1'b0);
        read_check(5'd7, 32'h0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Hard time bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

endmodule
